// File: rtl/v4_fsm_pkg.sv
// Shared definitions for the v4 serial FSM slice.
// Holds the transmitter state encoding, the frame preamble pattern and the
// default frame geometry used by v4_bitstream_tx.
package v4_fsm_pkg;

    // Transmitter states; PRE is only reachable when the preamble build is enabled.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } tx_state_t;

    // Preamble emitted MSB-first ahead of each frame; matches the detector's "011".
    localparam int unsigned PREAMBLE_LEN = 3;
    localparam logic [PREAMBLE_LEN-1:0] PREAMBLE = 3'b011;

    // Default frame geometry.
    localparam int unsigned DEF_DATA_W = 10;
    localparam int unsigned DEF_LEN_W  = 4;

endpackage

// File: rtl/v4_piso_shift.sv
// Parallel-in / serial-out left-shift register.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset (clears the register)
//   load       : capture din (has priority over shift)
//   shift      : shift left by one, zero fill at the LSB
//   din        : parallel load value
//   msb        : registered MSB, the current serial bit
module v4_piso_shift #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr_q;

    // Zero fill guarantees the register drains to all-zero once every loaded bit is out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= {sr_q[W-2:0], 1'b0};
        end
    end

    assign msb = sr_q[W-1];

endmodule

// File: rtl/v4_bitstream_tx.sv
// Serial bit-stream transmitter feeding the v4 "011" detector's bit_in.
// Accepts a frame over load_valid/load_ready, sends it MSB-first one bit per
// clock with bit_valid, then idles GAP_CYCLES cycles before accepting again.
// Optional macro V4_BITSTREAM_TX_PREAMBLE_EN prefixes every frame with 0,1,1.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   load_valid/load_ready : frame handshake (ready only in IDLE)
//   load_data, load_len   : frame bits (bit [len-1] first) and length; 0 or >DATA_W means DATA_W
//   bit_out, bit_valid    : serial bit and its qualifier (bit_out is 0 when not valid)
//   busy                  : high in any state other than IDLE
//   frame_done            : pulse with the last data bit
module v4_bitstream_tx
    import v4_fsm_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LEN_W      = DEF_LEN_W,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LEN_W-1:0]  load_len,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef V4_BITSTREAM_TX_PREAMBLE_EN
    localparam int unsigned SR_W = DATA_W + PREAMBLE_LEN;
`else
    localparam int unsigned SR_W = DATA_W;
`endif

    tx_state_t         state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
`ifdef V4_BITSTREAM_TX_PREAMBLE_EN
    logic [1:0]        pre_q, pre_d;
`endif
    logic              load_ready_q, load_ready_d;
    logic              bit_valid_q, bit_valid_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic              ld_c, sh_c;
    logic [LEN_W-1:0]  eff_len_c;
    logic [DATA_W-1:0] aligned_c;
    logic [SR_W-1:0]   sr_din_c;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gap_q        <= '0;
`ifdef V4_BITSTREAM_TX_PREAMBLE_EN
            pre_q        <= '0;
`endif
            load_ready_q <= 1'b1;
            bit_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
`ifdef V4_BITSTREAM_TX_PREAMBLE_EN
            pre_q        <= pre_d;
`endif
            load_ready_q <= load_ready_d;
            bit_valid_q  <= bit_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register in step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
`ifdef V4_BITSTREAM_TX_PREAMBLE_EN
        pre_d   = pre_q;
`endif
        ld_c    = 1'b0;
        sh_c    = 1'b0;

        eff_len_c = ((load_len == '0) || (load_len > LEN_W'(DATA_W))) ? LEN_W'(DATA_W) : load_len;
        aligned_c = load_data << (LEN_W'(DATA_W) - eff_len_c);
`ifdef V4_BITSTREAM_TX_PREAMBLE_EN
        sr_din_c  = {PREAMBLE, aligned_c};
`else
        sr_din_c  = aligned_c;
`endif

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    ld_c  = 1'b1;
                    cnt_d = eff_len_c;
`ifdef V4_BITSTREAM_TX_PREAMBLE_EN
                    pre_d   = 2'(PREAMBLE_LEN);
                    state_d = PRE;
`else
                    state_d = SHIFT;
`endif
                end
            end
`ifdef V4_BITSTREAM_TX_PREAMBLE_EN
            PRE: begin
                sh_c  = 1'b1;
                pre_d = pre_q - 2'd1;
                if (pre_q == 2'd1) begin
                    state_d = SHIFT;
                end
            end
`endif
            SHIFT: begin
                sh_c  = 1'b1;
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    if (GAP_CYCLES > 0) begin
                        gap_d   = GAP_W'(GAP_CYCLES);
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q == GAP_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        load_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        bit_valid_d  = (state_d == SHIFT) || (state_d == PRE);
        frame_done_d = (state_d == SHIFT) && (cnt_d == LEN_W'(1));
    end

    // Shift register MSB is a flop and reads 0 whenever no frame bit is in flight.
    v4_piso_shift #(
        .W (SR_W)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ld_c),
        .shift (sh_c),
        .din   (sr_din_c),
        .msb   (bit_out)
    );

    assign load_ready = load_ready_q;
    assign bit_valid  = bit_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_v4_bitstream_tx.sv
// Scoreboard bench for v4_bitstream_tx: the driver predicts, for every accepted
// frame, which cycle each wire bit appears in; a negedge monitor compares.
module tb_v4_bitstream_tx;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned GAP    = 2;
`ifdef V4_BITSTREAM_TX_PREAMBLE_EN
    localparam int unsigned PRE_N  = 3;
`else
    localparam int unsigned PRE_N  = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic [LEN_W-1:0]  load_len;
    logic              bit_out;
    logic              bit_valid;
    logic              busy;
    logic              frame_done;

    v4_bitstream_tx #(
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic        b;
        logic        d;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int unsigned ready_cyc;
    logic        exp_ready_w;
    logic        chk_en;
    int          errors;
    int          checks;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    // Reference model: a frame is a list of wire bits placed in consecutive cycles.
    task automatic accept(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
        int unsigned eff;
        int unsigned w;
        exp_t        e;
        eff = (l == 0 || l > DATA_W) ? DATA_W : int'(l);
        w   = cyc + 1;
        if (PRE_N > 0) begin
            e.d = 1'b0;
            e.cyc = w;     e.b = 1'b0; q.push_back(e);
            e.cyc = w + 1; e.b = 1'b1; q.push_back(e);
            e.cyc = w + 2; e.b = 1'b1; q.push_back(e);
            w = w + 3;
        end
        for (int i = int'(eff) - 1; i >= 0; i--) begin
            e.cyc = w;
            e.b   = d[i];
            e.d   = (i == 0);
            q.push_back(e);
            w++;
        end
        ready_cyc = cyc + eff + PRE_N + GAP + 1;
    endtask

    // One clock window: drive inputs, update the model, advance to #1 after the next edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d,
                        input logic [LEN_W-1:0] l, input logic r);
        exp_ready_w = (cyc >= ready_cyc);
        rst_n       = r;
        load_valid  = v;
        load_data   = d;
        load_len    = l;
        if (!r) begin
            while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
            ready_cyc = cyc + 1;
        end else if (v && exp_ready_w) begin
            accept(d, l);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle_until_ready(input int unsigned budget);
        for (int i = 0; i < int'(budget); i++) begin
            if (cyc >= ready_cyc && q.size() == 0) break;
            step(1'b0, DATA_W'($urandom), LEN_W'($urandom), 1'b1);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
        step(1'b1, d, l, 1'b1);
        idle_until_ready(40);
    endtask

    // Monitor: any cycle not owned by a predicted bit must be idle on the wire.
    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("bit_valid", bit_valid, 1'b1);
                chk("bit_out", bit_out, e.b);
                chk("frame_done", frame_done, e.d);
            end else begin
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    errors++;
                    $display("FAIL stale_entry cyc=%0d actual=missing expected_cyc=%0d", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
                chk("bit_valid_idle", bit_valid, 1'b0);
                chk("bit_out_idle", bit_out, 1'b0);
                chk("frame_done_idle", frame_done, 1'b0);
            end
            chk("load_ready", load_ready, exp_ready_w);
            chk("busy", busy, ~exp_ready_w);
        end
    end

    initial begin
        errors      = 0;
        checks      = 0;
        chk_en      = 1'b0;
        cyc         = 0;
        ready_cyc   = 0;
        exp_ready_w = 1'b1;
        rst_n       = 1'b0;
        load_valid  = 1'b1;
        load_data   = '1;
        load_len    = '0;
        @(posedge clk);
        cyc = 1;
        #1;
        chk_en = 1'b1;

        // Reset held two cycles with load_valid high: nothing accepted.
        step(1'b1, 10'h3FF, 4'd0, 1'b0);
        step(1'b1, 10'h3FF, 4'd0, 1'b0);
        step(1'b0, 10'h000, 4'd0, 1'b1);

        // Directed frames: full, short, clamp low, clamp high, preamble pattern.
        send(10'b0110011011, 4'd10);
        send(10'h003, 4'd3);
        send(10'h2C7, 4'd0);
        send(10'h1B5, 4'd15);
        send(10'h2A5, 4'd10);
        send(10'h001, 4'd1);

        // Busy ignore: offers while shifting are dropped; the held offer lands at ready.
        step(1'b1, 10'h155, 4'd10, 1'b1);
        step(1'b1, 10'h3FF, 4'd10, 1'b1);
        step(1'b1, 10'h000, 4'd4, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 10'h0F0, 4'd8, 1'b1);
        idle_until_ready(40);

        // Reset on the 4th bit cycle aborts the frame without frame_done.
        step(1'b1, 10'h3FF, 4'd10, 1'b1);
        for (int i = 0; i < int'(PRE_N) + 3; i++) step(1'b0, 10'h000, 4'd0, 1'b1);
        step(1'b0, 10'h000, 4'd0, 1'b0);
        step(1'b0, 10'h000, 4'd0, 1'b1);
        send(10'h2D2, 4'd6);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0), DATA_W'($urandom), LEN_W'($urandom_range(0, 15)),
                 ($urandom_range(0, 63) != 0));
        end
        idle_until_ready(60);
        step(1'b0, 10'h000, 4'd0, 1'b1);
        @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending bits", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
